pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the ID/EX pipeline register and the fetch stage. Each cycle it decides whether the PC and IF/ID register advance, whether ID/EX takes a bubble or holds its contents, and whether younger instructions are flushed. It sits beside the ID/EX buffer and drives that buffer's hold and flush controls, the PC write enable and the IF/ID write and flush controls. It handles load-use stalls, taken-branch flushes, multi-cycle EX operations and halt.

## Interface
Parameters:
- MULTI_LAT, 4: total cycles a multi-cycle op occupies EX. Legal range is ≥2.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous and active-low.
- id_op1, id_op2  in  4 each  source register ids of the instruction in ID.
- id_uses_op1, id_uses_op2  in  1 each  the ID instruction actually reads that source.
- ex_regDes  in  4  destination id of the instruction in EX (ID/EX output).
- ex_regWrite  in  1  the EX instruction writes a register.
- ex_memRead  in  1  the EX instruction is a load.
- ex_multi  in  1  the EX instruction is a multi-cycle op.
- ex_branch_taken  in  1  branch resolved taken in EX.
- halt  in  1  halt request.
- pcWrite  out  1  PC loads its next value.
- ifidWrite  out  1  IF/ID register captures.
- ifidFlush  out  1  IF/ID register is cleared to a NOP.
- idexFlush  out  1  ID/EX register captures a bubble (all control bits 0).
- idexHold  out  1  ID/EX register keeps its contents.
- busy  out  1  state is MULTI or HALT.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- State is RUN, MULTI or HALT. A down-counter `cnt` is ⌈log2 MULTI_LAT⌉ bits wide.
- All outputs are combinational from state and inputs (Mealy). The state, `cnt` and `stall_count` are registered.
- Default in RUN: pcWrite=1, ifidWrite=1, and all other controls 0.
- Load-use hazard: lu = ex_memRead & ex_regWrite & ((id_uses_op1 & id_op1==ex_regDes) | (id_uses_op2 & id_op2==ex_regDes)). Register 0 is not exempt.
- Events in RUN, in priority order:
  1. halt: pcWrite=0, ifidWrite=0, ifidFlush=1, idexFlush=1. Next state is HALT.
  2. ex_branch_taken: pcWrite=1, ifidFlush=1, idexFlush=1. The controller stays in RUN, and ex_multi and lu are ignored this cycle.
  3. ex_multi: pcWrite=0, ifidWrite=0, idexHold=1. Load cnt=MULTI_LAT-2 and go to MULTI.
  4. lu: pcWrite=0, ifidWrite=0, idexFlush=1. The controller stays in RUN, so the stall lasts exactly one cycle because the load moves to MEM.
- MULTI:
  - When halt=1, go to HALT with the halt outputs.
  - When cnt≠0: pcWrite=0, ifidWrite=0, idexHold=1, and cnt decrements.
  - When cnt==0 (release cycle): apply the RUN default outputs and go to RUN.
  - ex_multi, ex_branch_taken and lu are ignored in MULTI.
- HALT: pcWrite=0, ifidWrite=0, idexFlush=1, ifidFlush=0. HALT is left only by reset.
- idexHold and idexFlush are never both 1.
- stall_count increments on each non-reset cycle with pcWrite=0 and saturates at all ones.

## Timing
- Reset is sampled on the clk edge while rst=0. State goes to RUN, cnt to 0 and stall_count to 0.
- While rst=0, outputs are forced regardless of state: pcWrite=0, ifidWrite=0, ifidFlush=1, idexFlush=1, idexHold=0, busy=0.
- Reset overrides MULTI or HALT at that edge. The first cycle after rst rises is RUN.
- A multi-cycle op stalls fetch for exactly MULTI_LAT-1 cycles: the entry cycle plus MULTI_LAT-2 MULTI cycles. ID/EX advances on the MULTI_LAT-th cycle.
- For MULTI_LAT=2 there is one stall cycle, followed immediately by the release cycle.
- A load-use stall costs 1 cycle and inserts one bubble.
- A branch flush costs 0 stall cycles and discards 2 instructions.
- busy goes high the cycle after entry to MULTI or HALT and low in the cycle after the release cycle.

## Test plan
- Reset: hold rst=0 for 2 cycles with halt=1 → pcWrite=0, ifidFlush=1 and idexFlush=1 during reset. After release the state is RUN, stall_count=0 and busy=0.
- Load-use: ex_memRead=1, ex_regWrite=1, ex_regDes=5, id_op2=5, id_uses_op2=1 → exactly 1 cycle with pcWrite=0 and idexFlush=1, and stall_count=1. Repeat with id_uses_op2=0 → no stall.
- Multi-cycle: MULTI_LAT=4, ex_multi=1 held → pcWrite=0 and idexHold=1 for 3 cycles, then the release cycle has pcWrite=1. stall_count=3. Repeat with MULTI_LAT=2 → 1 stall cycle.
- Simultaneous events: ex_branch_taken=1 together with lu=1 and ex_multi=1 → pcWrite=1, ifidFlush=1, idexFlush=1, and the state stays RUN.
- Halt inside MULTI: assert halt at cnt=1 → next state HALT with pcWrite=0 and idexFlush=1 every cycle. Then rst=0 for one edge → RUN.
- Saturation: CNT_W=4, halt held for 20 cycles → stall_count stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for fetch, IF/ID and ID/EX: load-use, branch flush, multi-cycle EX, halt.
// Latency: all controls are combinational (Mealy) from state and inputs; state, cnt and stall_count registered.
// Backpressure: stalls deassert pcWrite/ifidWrite; ID/EX is either held or bubbled, never both.
module pipeline_hazard_ctrl #(
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_op1,
    input  logic [3:0]       id_op2,
    input  logic             id_uses_op1,
    input  logic             id_uses_op2,
    input  logic [3:0]       ex_regDes,
    input  logic             ex_regWrite,
    input  logic             ex_memRead,
    input  logic             ex_multi,
    input  logic             ex_branch_taken,
    input  logic             halt,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             idexHold,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int CW = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_LAT - 2);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MULTI = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lu;

    assign lu = ex_memRead & ex_regWrite &
                ((id_uses_op1 & (id_op1 == ex_regDes)) |
                 (id_uses_op2 & (id_op2 == ex_regDes)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        idexHold  = 1'b0;
        busy      = 1'b0;

        if (!rst) begin
            // Reset drains both pipeline registers while the PC is frozen.
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
            state_nxt = S_RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_RUN: begin
                    pcWrite   = 1'b1;
                    ifidWrite = 1'b1;
                    if (halt) begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                        state_nxt = S_HALT;
                    end else if (ex_branch_taken) begin
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                    end else if (ex_multi) begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        idexHold  = 1'b1;
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = S_MULTI;
                    end else if (lu) begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        idexFlush = 1'b1;
                    end
                end
                S_MULTI: begin
                    busy = 1'b1;
                    if (halt) begin
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                        state_nxt = S_HALT;
                    end else if (cnt != '0) begin
                        idexHold = 1'b1;
                        cnt_nxt  = cnt - CW'(1);
                    end else begin
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                        state_nxt = S_RUN;
                    end
                end
                S_HALT: begin
                    busy      = 1'b1;
                    idexFlush = 1'b1;
                end
                default: begin
                    state_nxt = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pcWrite && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: RUN-state vector table plus multi-cycle, halt and saturation sequences.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] id_op1, id_op2, ex_regDes;
    logic       id_uses_op1, id_uses_op2, ex_regWrite, ex_memRead;
    logic       ex_multi, ex_branch_taken, halt;

    logic        pw_a, iw_a, if_a, xf_a, xh_a, by_a;
    logic        pw_b, iw_b, if_b, xf_b, xh_b, by_b;
    logic        pw_c, iw_c, if_c, xf_c, xh_c, by_c;
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    wire [5:0] outs_a = {pw_a, iw_a, if_a, xf_a, xh_a, by_a};
    wire [5:0] outs_b = {pw_b, iw_b, if_b, xf_b, xh_b, by_b};

    pipeline_hazard_ctrl #(.MULTI_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_op1(id_op1), .id_op2(id_op2),
        .id_uses_op1(id_uses_op1), .id_uses_op2(id_uses_op2),
        .ex_regDes(ex_regDes), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_multi(ex_multi), .ex_branch_taken(ex_branch_taken), .halt(halt),
        .pcWrite(pw_a), .ifidWrite(iw_a), .ifidFlush(if_a), .idexFlush(xf_a),
        .idexHold(xh_a), .busy(by_a), .stall_count(sc_a));

    pipeline_hazard_ctrl #(.MULTI_LAT(2), .CNT_W(16)) dut_lat2 (
        .clk(clk), .rst(rst), .id_op1(id_op1), .id_op2(id_op2),
        .id_uses_op1(id_uses_op1), .id_uses_op2(id_uses_op2),
        .ex_regDes(ex_regDes), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_multi(ex_multi), .ex_branch_taken(ex_branch_taken), .halt(halt),
        .pcWrite(pw_b), .ifidWrite(iw_b), .ifidFlush(if_b), .idexFlush(xf_b),
        .idexHold(xh_b), .busy(by_b), .stall_count(sc_b));

    pipeline_hazard_ctrl #(.MULTI_LAT(4), .CNT_W(4)) dut_cnt4 (
        .clk(clk), .rst(rst), .id_op1(id_op1), .id_op2(id_op2),
        .id_uses_op1(id_uses_op1), .id_uses_op2(id_uses_op2),
        .ex_regDes(ex_regDes), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_multi(ex_multi), .ex_branch_taken(ex_branch_taken), .halt(halt),
        .pcWrite(pw_c), .ifidWrite(iw_c), .ifidFlush(if_c), .idexFlush(xf_c),
        .idexHold(xh_c), .busy(by_c), .stall_count(sc_c));

    // Expected output order: {pcWrite, ifidWrite, ifidFlush, idexFlush, idexHold, busy}
    typedef struct {
        logic [3:0] op1;
        logic [3:0] op2;
        logic       u1;
        logic       u2;
        logic [3:0] des;
        logic       rw;
        logic       mr;
        logic       mu;
        logic       br;
        logic       hl;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt;

    function automatic vec_t mk(input logic [3:0] op1, input logic [3:0] op2,
                                input logic u1, input logic u2, input logic [3:0] des,
                                input logic rw, input logic mr, input logic mu,
                                input logic br, input logic hl, input logic [5:0] exp);
        vec_t v;
        v.op1 = op1; v.op2 = op2; v.u1 = u1; v.u2 = u2; v.des = des;
        v.rw = rw; v.mr = mr; v.mu = mu; v.br = br; v.hl = hl; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        id_op1 = 4'd0; id_op2 = 4'd0; id_uses_op1 = 1'b0; id_uses_op2 = 1'b0;
        ex_regDes = 4'd0; ex_regWrite = 1'b0; ex_memRead = 1'b0;
        ex_multi = 1'b0; ex_branch_taken = 1'b0; halt = 1'b0;
    endtask

    // Two reset edges; returns at a negedge in the first RUN cycle.
    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [5:0] ma [5];
    logic [5:0] mb [5];
    logic       mu_in [5];
    logic [5:0] hx [5];
    logic       hm [5];
    logic       hh [5];

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
        vecs[1]  = mk(3, 7, 1, 1, 3, 1, 1, 0, 0, 0, 6'b000100);
        vecs[2]  = mk(1, 5, 1, 1, 5, 1, 1, 0, 0, 0, 6'b000100);
        vecs[3]  = mk(1, 5, 1, 0, 5, 1, 1, 0, 0, 0, 6'b110000);
        vecs[4]  = mk(5, 5, 1, 1, 5, 1, 0, 0, 0, 0, 6'b110000);
        vecs[5]  = mk(5, 5, 1, 1, 5, 0, 1, 0, 0, 0, 6'b110000);
        vecs[6]  = mk(0, 9, 1, 0, 0, 1, 1, 0, 0, 0, 6'b000100);
        vecs[7]  = mk(5, 5, 0, 0, 5, 1, 1, 0, 0, 0, 6'b110000);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111100);
        vecs[9]  = mk(5, 5, 1, 1, 5, 1, 1, 1, 1, 0, 6'b111100);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);

        ma    = '{6'b000010, 6'b000011, 6'b000011, 6'b110001, 6'b110000};
        mb    = '{6'b000010, 6'b110001, 6'b000010, 6'b110001, 6'b110000};
        mu_in = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        hm = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        hh = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        hx = '{6'b000010, 6'b000011, 6'b001101, 6'b000101, 6'b000101};

        // Reset with halt asserted: reset forcing wins.
        rst = 1'b0;
        set_idle();
        halt = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("reset_outputs", outs_a, 6'b001100);
        end
        check("reset_stall_count", sc_a, 0);
        rst  = 1'b1;
        halt = 1'b0;
        #1;
        check("post_reset_run", outs_a, 6'b110000);
        check("post_reset_count", sc_a, 0);
        @(negedge clk);

        exp_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            id_op1 = vecs[i].op1; id_op2 = vecs[i].op2;
            id_uses_op1 = vecs[i].u1; id_uses_op2 = vecs[i].u2;
            ex_regDes = vecs[i].des; ex_regWrite = vecs[i].rw; ex_memRead = vecs[i].mr;
            ex_multi = vecs[i].mu; ex_branch_taken = vecs[i].br; halt = vecs[i].hl;
            #1;
            check($sformatf("vec%0d_outputs", i), outs_a, vecs[i].exp);
            check($sformatf("vec%0d_stall_count", i), sc_a, exp_cnt);
            if (!vecs[i].exp[5]) exp_cnt++;
            @(negedge clk);
        end
        set_idle();
        #1;
        check("table_stall_total", sc_a, 3);

        // Multi-cycle op: LAT4 stalls 3 cycles; LAT2 stalls 1 and re-enters while ex_multi stays high.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ex_multi = mu_in[i];
            #1;
            check($sformatf("multi4_c%0d", i), outs_a, ma[i]);
            check($sformatf("multi2_c%0d", i), outs_b, mb[i]);
            @(negedge clk);
        end
        #1;
        check("multi4_stall_count", sc_a, 3);
        check("multi2_stall_count", sc_b, 2);

        // Halt arriving inside MULTI at cnt=1, then HALT until reset.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ex_multi = hm[i];
            halt     = hh[i];
            #1;
            check($sformatf("halt_multi_c%0d", i), outs_a, hx[i]);
            if (i == 4) check("halt_stall_count", sc_a, 4);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("halt_reset_outputs", outs_a, 6'b001100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("halt_exit_run", outs_a, 6'b110000);
        @(negedge clk);

        // Saturation of the narrow counter under a long halt.
        do_reset();
        halt = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("sat_cnt4_at15", sc_c, 15);
        check("wide_cnt_at15", sc_a, 15);
        repeat (5) @(negedge clk);
        #1;
        check("sat_cnt4_at20", sc_c, 15);
        check("wide_cnt_at20", sc_a, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
